// File: rtl/qspi_pkg.sv
// qspi_pkg: shared types and constants for the quad-SPI initiator.
// Imported by qspi_master and qspi_clkgen.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    TURN,
    RDATA,
    HOLD
  } state_t;

  localparam int         NIB_PER_BYTE = 2;
  localparam logic [3:0] OE_ALL       = 4'hF;

endpackage

// File: rtl/qspi_clkgen.sv
// qspi_clkgen: QCK half-period divider with rise/fall ticks.
// Disabling it parks QCK low and restarts the half-period.
module qspi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic qck,
  output logic rise,
  output logic fall
);
  import qspi_pkg::*;

  logic [15:0] cnt;
  logic        last;

  assign last = (cnt == 16'(CLK_DIV - 1));
  assign rise = en && last && !qck;
  assign fall = en && last && qck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      qck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      qck <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      qck <= ~qck;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/qspi_master.sv
// qspi_master: mode-0 quad-SPI initiator, opcode plus 0-255 bytes.
// QCK stalls low while tx is empty or rx is still held.
module qspi_master #(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic       io_mainClk,
  input  logic       io_asyncReset_n,
  input  logic       io_cmd_valid,
  output logic       io_cmd_ready,
  input  logic [7:0] io_cmd_payload_opcode,
  input  logic       io_cmd_payload_read,
  input  logic [7:0] io_cmd_payload_length,
  input  logic       io_tx_valid,
  output logic       io_tx_ready,
  input  logic [7:0] io_tx_payload,
  output logic       io_rx_valid,
  input  logic       io_rx_ready,
  output logic [7:0] io_rx_payload,
  output logic       io_qspi_qss,
  output logic       io_qspi_qck,
  input  logic [3:0] io_qspi_qd_read,
  output logic [3:0] io_qspi_qd_write,
  output logic [3:0] io_qspi_qd_writeEnable,
  output logic       io_busy
);
  import qspi_pkg::*;

  state_t      state, state_n;
  logic [7:0]  sh, sh_n, cnt, cnt_n, rxb, rxb_n;
  logic [7:0]  dcnt, dcnt_n;
  logic [15:0] hcnt, hcnt_n;
  logic [3:0]  qd, qd_n, oe, oe_n;
  logic        nib, nib_n, rd, rd_n, pend, pend_n;
  logic        rxv, rxv_n, qss, qss_n;
  logic        busy, busy_n, crdy, crdy_n;
  logic        en, qck, rise, fall, last_nib, take;

  qspi_clkgen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk  (io_mainClk),
    .rst_n(io_asyncReset_n),
    .en   (en),
    .qck  (qck),
    .rise (rise),
    .fall (fall)
  );

  assign last_nib = (nib == 1'(NIB_PER_BYTE - 1));

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    rxb_n   = rxb;
    dcnt_n  = dcnt;
    hcnt_n  = hcnt;
    qd_n    = qd;
    oe_n    = oe;
    nib_n   = nib;
    rd_n    = rd;
    pend_n  = pend;
    rxv_n   = rxv;
    qss_n   = qss;
    busy_n  = busy;
    en      = 1'b0;
    take    = 1'b0;
    if (rxv && io_rx_ready) rxv_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (io_cmd_valid && crdy) begin
          state_n = CMD;
          sh_n    = io_cmd_payload_opcode;
          qd_n    = io_cmd_payload_opcode[7:4];
          oe_n    = OE_ALL;
          qss_n   = 1'b0;
          rd_n    = io_cmd_payload_read;
          cnt_n   = io_cmd_payload_length;
          nib_n   = 1'b0;
          pend_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      CMD: begin
        en = 1'b1;
        if (fall) begin
          if (!last_nib) begin
            qd_n  = sh[3:0];
            nib_n = 1'b1;
          end else if (cnt == 8'd0) begin
            state_n = HOLD;
            oe_n    = '0;
            hcnt_n  = '0;
          end else if (rd) begin
            state_n = TURN;
            oe_n    = '0;
            dcnt_n  = '0;
          end else begin
            state_n = WDATA;
            if (io_tx_valid) take = 1'b1;
            else pend_n = 1'b1;
          end
        end
      end
      WDATA: begin
        if (pend) begin
          take = io_tx_valid;
        end else begin
          en = 1'b1;
          if (fall) begin
            if (!last_nib) begin
              qd_n  = sh[3:0];
              nib_n = 1'b1;
            end else begin
              cnt_n = cnt - 8'd1;
              if (cnt == 8'd1) begin
                state_n = HOLD;
                oe_n    = '0;
                hcnt_n  = '0;
              end else if (io_tx_valid) begin
                take = 1'b1;
              end else begin
                pend_n = 1'b1;
              end
            end
          end
        end
      end
      TURN: begin
        en = 1'b1;
        if (fall) begin
          if (dcnt == 8'(DUMMY_CYCLES - 1)) begin
            state_n = RDATA;
            nib_n   = 1'b0;
          end else begin
            dcnt_n = dcnt + 8'd1;
          end
        end
      end
      RDATA: begin
        // Park low before a new byte while the last one is unread.
        en = !(!nib && !qck && rxv);
        if (rise) begin
          sh_n = {sh[3:0], io_qspi_qd_read};
          if (!last_nib) begin
            nib_n = 1'b1;
          end else begin
            nib_n = 1'b0;
            rxb_n = {sh[3:0], io_qspi_qd_read};
            rxv_n = 1'b1;
            cnt_n = cnt - 8'd1;
          end
        end else if (fall && !nib && cnt == 8'd0) begin
          state_n = HOLD;
          hcnt_n  = '0;
        end
      end
      HOLD: begin
        hcnt_n = hcnt + 16'd1;
        if (hcnt == 16'(CLK_DIV - 1)) qss_n = 1'b1;
        if (hcnt == 16'(2 * CLK_DIV - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      sh_n   = io_tx_payload;
      qd_n   = io_tx_payload[7:4];
      nib_n  = 1'b0;
      pend_n = 1'b0;
    end
    crdy_n = (state_n == IDLE);
  end

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      rxb   <= '0;
      dcnt  <= '0;
      hcnt  <= '0;
      qd    <= '0;
      oe    <= '0;
      nib   <= 1'b0;
      rd    <= 1'b0;
      pend  <= 1'b0;
      rxv   <= 1'b0;
      qss   <= 1'b1;
      busy  <= 1'b0;
      crdy  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      rxb   <= rxb_n;
      dcnt  <= dcnt_n;
      hcnt  <= hcnt_n;
      qd    <= qd_n;
      oe    <= oe_n;
      nib   <= nib_n;
      rd    <= rd_n;
      pend  <= pend_n;
      rxv   <= rxv_n;
      qss   <= qss_n;
      busy  <= busy_n;
      crdy  <= crdy_n;
    end
  end

  assign io_cmd_ready           = crdy;
  assign io_tx_ready            = take;
  assign io_rx_valid            = rxv;
  assign io_rx_payload          = rxb;
  assign io_qspi_qss            = qss;
  assign io_qspi_qck            = qck;
  assign io_qspi_qd_write       = qd;
  assign io_qspi_qd_writeEnable = oe;
  assign io_busy                = busy;

endmodule

// File: tb/tb_qspi_master.sv
// tb_qspi_master: directed bench for qspi_master, CLK_DIV=2, DUMMY=2.
// A negedge monitor logs QCK rises, handshakes and drives qd_read.
module tb_qspi_master;
  localparam int CLK_DIV = 2;
  localparam int DUMMY   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_read;
  logic [7:0] cmd_op, cmd_len;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_payload;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_payload;
  logic       qss, qck, busy;
  logic [3:0] qd_read = 4'h0;
  logic [3:0] qd_write, oe;

  always #5 clk = ~clk;

  qspi_master #(.CLK_DIV(CLK_DIV), .DUMMY_CYCLES(DUMMY)) dut (
    .io_mainClk            (clk),
    .io_asyncReset_n       (rst_n),
    .io_cmd_valid          (cmd_valid),
    .io_cmd_ready          (cmd_ready),
    .io_cmd_payload_opcode (cmd_op),
    .io_cmd_payload_read   (cmd_read),
    .io_cmd_payload_length (cmd_len),
    .io_tx_valid           (tx_valid),
    .io_tx_ready           (tx_ready),
    .io_tx_payload         (tx_payload),
    .io_rx_valid           (rx_valid),
    .io_rx_ready           (rx_ready),
    .io_rx_payload         (rx_payload),
    .io_qspi_qss           (qss),
    .io_qspi_qck           (qck),
    .io_qspi_qd_read       (qd_read),
    .io_qspi_qd_write      (qd_write),
    .io_qspi_qd_writeEnable(oe),
    .io_busy               (busy)
  );

  int checks = 0;
  int errors = 0;

  logic       qck_q = 1'b0;
  logic       qss_q = 1'b1;
  int         rises = 0, pre = 0, qss_low = 0, hold_cyc = 0;
  int         txhs = 0, rxhs = 0, fcnt = 0, ridx = 0;
  logic       tx_hs_now = 1'b0;
  logic [3:0] rnib[$];
  logic [3:0] roe[$];
  logic [7:0] rxq[$];
  logic       rdmode;
  logic [3:0] rtab[4];

  always @(negedge clk) begin
    if (!qss && qss_q) begin
      rises = 0; pre = 0; qss_low = 0; hold_cyc = 0;
      txhs = 0; rxhs = 0; fcnt = 0; ridx = 0;
      rnib.delete(); roe.delete(); rxq.delete();
    end
    if (!qss) qss_low++;
    if (qss && busy) hold_cyc++;
    if (!qss && !qck && rises == 0) pre++;
    if (qck && !qck_q) begin
      rises++;
      rnib.push_back(qd_write);
      roe.push_back(oe);
    end
    if (!qck && qck_q) begin
      fcnt++;
      if (rdmode && fcnt >= 4 && ridx < 4) begin
        qd_read = rtab[ridx];
        ridx++;
      end
    end
    tx_hs_now = tx_valid && tx_ready;
    if (tx_hs_now) txhs++;
    if (rx_valid && rx_ready) begin
      rxhs++;
      rxq.push_back(rx_payload);
    end
    qck_q = qck;
    qss_q = qss;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic rd,
                      input logic [7:0] len);
    logic acc, r;
    acc = 1'b0;
    cmd_op = op; cmd_read = rd; cmd_len = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = cmd_ready;
      tick();
      if (r) begin
        acc = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", acc, 1'b1);
  endtask

  task automatic wait_tx(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_hs_now) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (!busy && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
  endtask

  function automatic logic [23:0] nib_seq();
    logic [23:0] s;
    s = '0;
    foreach (rnib[i]) s = {s[19:0], rnib[i]};
    return s;
  endfunction

  function automatic logic oe_all_f();
    logic a;
    a = 1'b1;
    foreach (roe[i]) a = a && (roe[i] == 4'hF);
    return a;
  endfunction

  task automatic run_write(input string tag, input logic [7:0] op,
                           input logic [7:0] len, input logic [15:0] data,
                           input int gap, input logic [23:0] exp_seq);
    tx_payload = data[15:8];
    tx_valid   = 1'b1;
    send(op, 1'b0, len);
    for (int i = 0; i < int'(len); i++) begin
      tx_payload = (i == 0) ? data[15:8] : data[7:0];
      tx_valid   = 1'b1;
      wait_tx({tag, "_tx"});
      tx_valid = 1'b0;
      if (gap > 0 && i == 0) begin
        repeat (gap) tick();
        chk({tag, "_gap_qck"}, qck, 1'b0);
        chk({tag, "_gap_rises"}, rises, 4);
        chk({tag, "_gap_qss"}, qss, 1'b0);
      end
    end
    wait_idle({tag, "_idle"});
    chk({tag, "_rises"}, rises, 2 + 2 * int'(len));
    chk({tag, "_nibs"}, nib_seq(), exp_seq);
    chk({tag, "_oe"}, oe_all_f(), 1'b1);
    chk({tag, "_txhs"}, txhs, int'(len));
    chk({tag, "_qss"}, qss, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_read(input string tag, input logic [7:0] op,
                          input logic [15:0] tab, input int stall,
                          input logic [7:0] e0, input logic [7:0] e1);
    logic ok;
    int   r0;
    rdmode  = 1'b1;
    rtab[0] = tab[15:12];
    rtab[1] = tab[11:8];
    rtab[2] = tab[7:4];
    rtab[3] = tab[3:0];
    if (stall > 0) rx_ready = 1'b0;
    send(op, 1'b1, 8'd2);
    if (stall > 0) begin
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (rx_valid) begin
          ok = 1'b1;
          break;
        end
      end
      chk({tag, "_rxv_wait"}, ok, 1'b1);
      repeat (5) tick();
      r0 = rises;
      repeat (stall) tick();
      chk({tag, "_frozen"}, rises, r0);
      chk({tag, "_stall_qck"}, qck, 1'b0);
      chk({tag, "_stall_rxv"}, rx_valid, 1'b1);
      chk({tag, "_stall_pay"}, rx_payload, e0);
      rx_ready = 1'b1;
    end
    wait_idle({tag, "_idle"});
    chk({tag, "_rises"}, rises, 8);
    chk({tag, "_nib0"}, rnib[0], op[7:4]);
    chk({tag, "_nib1"}, rnib[1], op[3:0]);
    chk({tag, "_oe_cmd"}, roe[1], 4'hF);
    chk({tag, "_oe_turn"}, roe[2], 4'h0);
    chk({tag, "_oe_data"}, roe[7], 4'h0);
    chk({tag, "_rxn"}, rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk({tag, "_rx0"}, rxq[0], e0);
      chk({tag, "_rx1"}, rxq[1], e1);
    end
    chk({tag, "_txhs"}, txhs, 0);
    rdmode = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_read = 1'b0; cmd_len = '0;
    tx_valid = 1'b0; tx_payload = '0; rx_ready = 1'b1;
    rdmode = 1'b0;
    rtab[0] = '0; rtab[1] = '0; rtab[2] = '0; rtab[3] = '0;
    repeat (3) tick();
    chk("rst_qss", qss, 1'b1);
    chk("rst_qck", qck, 1'b0);
    chk("rst_qd", qd_write, 4'h0);
    chk("rst_oe", oe, 4'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_payload", rx_payload, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("cmd_ready_after_rst", cmd_ready, 1'b1);

    run_write("wr", 8'h02, 8'd2, 16'hA53C, 0, 24'h02A53C);
    chk("wr_pre_rise", pre, CLK_DIV);

    run_read("rd", 8'h03, 16'h1234, 0, 8'h12, 8'h34);

    send(8'hFF, 1'b0, 8'd0);
    wait_idle("op_idle");
    chk("op_rises", rises, 2);
    chk("op_txhs", txhs, 0);
    chk("op_rxhs", rxhs, 0);
    chk("op_qss_low", qss_low, 4 * CLK_DIV + CLK_DIV);
    chk("op_hold", hold_cyc, CLK_DIV);
    chk("op_nibs", nib_seq(), 24'h0000FF);

    run_write("gap", 8'h12, 8'd2, 16'h9E47, 10, 24'h129E47);

    run_read("rst", 8'h0B, 16'h5678, 20, 8'h56, 8'h78);

    tx_payload = 8'hB7;
    tx_valid   = 1'b1;
    send(8'h5A, 1'b0, 8'd3);
    wait_tx("mid_tx");
    tx_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_qss", qss, 1'b1);
    chk("mid_qck", qck, 1'b0);
    chk("mid_oe", oe, 4'h0);
    chk("mid_qd", qd_write, 4'h0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_cmd_ready", cmd_ready, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_write("post", 8'h21, 8'd1, 16'hC300, 0, 24'h0021C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
